// File: rtl/video_rx_monitor_if.sv
// video_if: parallel video link between the vga controller (master) and
// receivers such as video_rx_monitor (slave).
//   hs    : horizontal sync, active low
//   vs    : vertical sync, active low
//   blank : high while an active pixel is on rgb
//   rgb   : 24-bit pixel data
interface video_if;
    logic        hs;
    logic        vs;
    logic        blank;
    logic [23:0] rgb;

    modport master (output hs, vs, blank, rgb);
    modport slave  (input  hs, vs, blank, rgb);
endinterface

// File: rtl/video_rx_monitor.sv
// video_rx_monitor: samples a video_if link, rebuilds pixel coordinates,
// checks active geometry against HDISP x VDISP and reports per-frame lock
// status, frame count and a 24-bit additive RGB checksum.
// Ports:
//   pixel_clk, sys_rst      clock, asynchronous active-high reset
//   video_ifs               video_if slave (hs, vs, blank, rgb)
//   pix_valid/x/y/rgb       active pixel stream, 2-cycle latency
//   sof                     pulse on first valid pixel of a frame
//   frame_done, frame_sum   pulse + checksum when a frame closes
//   frame_cnt, locked       good frames since lock, lock status
//   err_geom                pulse on line or frame geometry mismatch
module video_rx_monitor #(
    parameter int HDISP = 800,
    parameter int VDISP = 480
) (
    input  logic        pixel_clk,
    input  logic        sys_rst,
    video_if.slave      video_ifs,
    output logic        pix_valid,
    output logic [10:0] pix_x,
    output logic [10:0] pix_y,
    output logic [23:0] pix_rgb,
    output logic        sof,
    output logic        frame_done,
    output logic [23:0] frame_sum,
    output logic [15:0] frame_cnt,
    output logic        locked,
    output logic        err_geom
);
    localparam logic [10:0] HDISP_W = 11'(HDISP);
    localparam logic [10:0] VDISP_W = 11'(VDISP);

    typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

    state_t      state_q, state_d;
    logic        s1_hs_q, s1_vs_q, s1_blank_q;
    logic [23:0] s1_rgb_q;
    logic        p_hs_q, p_vs_q, p_blank_q;
    logic [10:0] x_q, x_d, y_q, y_d;
    logic [23:0] sum_q, sum_d;
    logic        bad_q, bad_d;
    logic        sof_pend_q, sof_pend_d;
    logic        pix_valid_q, pix_valid_d;
    logic [10:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic [23:0] pix_rgb_q, pix_rgb_d;
    logic        sof_q, sof_d, done_q, done_d, locked_q, locked_d, err_q, err_d;
    logic [23:0] fsum_q, fsum_d;
    logic [15:0] fcnt_q, fcnt_d;

    logic vs_fall, hs_fall, bl_fall, checking, active, line_err, frame_err, good;
    logic [10:0] x_cur;

    always_comb begin
        vs_fall   = p_vs_q & ~s1_vs_q;
        hs_fall   = p_hs_q & ~s1_hs_q;
        bl_fall   = p_blank_q & ~s1_blank_q;
        checking  = (state_q != SEARCH);
        active    = s1_blank_q & checking;
        x_cur     = hs_fall ? 11'd0 : x_q;
        // x_q still holds the length of the run that just ended
        line_err  = checking & bl_fall & (x_q != HDISP_W);
        // a line closing in the VS-fall cycle still belongs to the old frame
        frame_err = checking & vs_fall & ((y_q + 11'(bl_fall)) != VDISP_W);
        good      = ~bad_q & ~line_err & ~frame_err;

        // counters track the raw stream so they are coherent when checking starts
        x_d   = x_cur + 11'(s1_blank_q);
        y_d   = vs_fall ? 11'd0 : (y_q + 11'(bl_fall));
        sum_d = (vs_fall ? 24'd0 : sum_q) + (s1_blank_q ? s1_rgb_q : 24'd0);

        pix_valid_d = active;
        pix_x_d     = x_cur;
        pix_y_d     = vs_fall ? 11'd0 : y_q;
        pix_rgb_d   = active ? s1_rgb_q : pix_rgb_q;
        sof_d       = active & (sof_pend_q | vs_fall);
        sof_pend_d  = active ? 1'b0 : (sof_pend_q | vs_fall);
        err_d       = line_err | frame_err;

        state_d  = state_q;
        bad_d    = bad_q | line_err;
        locked_d = locked_q;
        fcnt_d   = fcnt_q;
        fsum_d   = fsum_q;
        done_d   = 1'b0;
        if (vs_fall) begin
            bad_d = 1'b0;
            case (state_q)
                SEARCH: state_d = CHECK;
                CHECK: begin
                    done_d = 1'b1;
                    fsum_d = sum_q;
                    if (good) begin
                        state_d  = LOCKED;
                        locked_d = 1'b1;
                        fcnt_d   = 16'd1;
                    end
                end
                LOCKED: begin
                    done_d = 1'b1;
                    fsum_d = sum_q;
                    if (good) begin
                        fcnt_d = fcnt_q + 16'd1;
                    end else begin
                        state_d  = CHECK;
                        locked_d = 1'b0;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    always_ff @(posedge pixel_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= SEARCH;
            s1_hs_q     <= 1'b0;
            s1_vs_q     <= 1'b0;
            s1_blank_q  <= 1'b0;
            s1_rgb_q    <= 24'd0;
            p_hs_q      <= 1'b0;
            p_vs_q      <= 1'b0;
            p_blank_q   <= 1'b0;
            x_q         <= 11'd0;
            y_q         <= 11'd0;
            sum_q       <= 24'd0;
            bad_q       <= 1'b0;
            sof_pend_q  <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_x_q     <= 11'd0;
            pix_y_q     <= 11'd0;
            pix_rgb_q   <= 24'd0;
            sof_q       <= 1'b0;
            done_q      <= 1'b0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
            fsum_q      <= 24'd0;
            fcnt_q      <= 16'd0;
        end else begin
            state_q     <= state_d;
            s1_hs_q     <= video_ifs.hs;
            s1_vs_q     <= video_ifs.vs;
            s1_blank_q  <= video_ifs.blank;
            s1_rgb_q    <= video_ifs.rgb;
            p_hs_q      <= s1_hs_q;
            p_vs_q      <= s1_vs_q;
            p_blank_q   <= s1_blank_q;
            x_q         <= x_d;
            y_q         <= y_d;
            sum_q       <= sum_d;
            bad_q       <= bad_d;
            sof_pend_q  <= sof_pend_d;
            pix_valid_q <= pix_valid_d;
            pix_x_q     <= pix_x_d;
            pix_y_q     <= pix_y_d;
            pix_rgb_q   <= pix_rgb_d;
            sof_q       <= sof_d;
            done_q      <= done_d;
            locked_q    <= locked_d;
            err_q       <= err_d;
            fsum_q      <= fsum_d;
            fcnt_q      <= fcnt_d;
        end
    end

    assign pix_valid  = pix_valid_q;
    assign pix_x      = pix_x_q;
    assign pix_y      = pix_y_q;
    assign pix_rgb    = pix_rgb_q;
    assign sof        = sof_q;
    assign frame_done = done_q;
    assign frame_sum  = fsum_q;
    assign frame_cnt  = fcnt_q;
    assign locked     = locked_q;
    assign err_geom   = err_q;
endmodule

// File: tb/tb_video_rx_monitor.sv
module tb_video_rx_monitor;
    localparam int HD = 8;
    localparam int VD = 4;

    logic        pixel_clk = 1'b0;
    logic        sys_rst   = 1'b1;
    logic        pix_valid, sof, frame_done, locked, err_geom;
    logic [10:0] pix_x, pix_y;
    logic [23:0] pix_rgb, frame_sum;
    logic [15:0] frame_cnt;

    video_if vif ();

    video_rx_monitor #(.HDISP(HD), .VDISP(VD)) dut (
        .pixel_clk (pixel_clk),
        .sys_rst   (sys_rst),
        .video_ifs (vif),
        .pix_valid (pix_valid),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_rgb   (pix_rgb),
        .sof       (sof),
        .frame_done(frame_done),
        .frame_sum (frame_sum),
        .frame_cnt (frame_cnt),
        .locked    (locked),
        .err_geom  (err_geom)
    );

    always #5 pixel_clk = ~pixel_clk;

    typedef struct {
        logic        v;
        logic [10:0] x;
        logic [10:0] y;
        logic [23:0] rgb;
        logic        sof;
    } exp_t;

    typedef struct {
        int          nlines;
        int          bad_line;
        int          bad_len;
        int          mode;
        int          exp_locked;
        int          exp_cnt;
        int          exp_done;
        logic [23:0] exp_sum;
        int          exp_err;
    } row_t;

    int          checks   = 0;
    int          failures = 0;
    int          err_cnt  = 0;
    int          done_cnt = 0;
    logic [23:0] last_sum = 24'd0;
    logic        search   = 1'b1;
    exp_t        e0, e1;
    row_t        rows [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " pix_valid"},  32'(pix_valid),  32'd0);
        chk({tag, " pix_x"},      32'(pix_x),      32'd0);
        chk({tag, " pix_y"},      32'(pix_y),      32'd0);
        chk({tag, " pix_rgb"},    32'(pix_rgb),    32'd0);
        chk({tag, " sof"},        32'(sof),        32'd0);
        chk({tag, " frame_done"}, 32'(frame_done), 32'd0);
        chk({tag, " frame_sum"},  32'(frame_sum),  32'd0);
        chk({tag, " frame_cnt"},  32'(frame_cnt),  32'd0);
        chk({tag, " locked"},     32'(locked),     32'd0);
        chk({tag, " err_geom"},   32'(err_geom),   32'd0);
    endtask

    function automatic logic [23:0] rgb_of(input int mode, input int p, input int l);
        case (mode)
            1:       return 24'h000001;
            2:       return (l == 0 && p < 2) ? 24'hFFFFFF : 24'h000000;
            default: return 24'(p + 16 * l);
        endcase
    endfunction

    // One pixel clock: check what the DUT shows for the input driven two
    // calls ago, then drive this cycle's input and its expectation.
    task automatic cyc(input logic hs, input logic vs, input logic blank, input logic [23:0] rgb,
                       input logic ev, input int ex, input int ey, input logic esof);
        @(negedge pixel_clk);
        chk("pix_valid", 32'(pix_valid), 32'(e1.v));
        chk("sof", 32'(sof), 32'(e1.sof));
        if (e1.v) begin
            chk("pix_x",   32'(pix_x),   32'(e1.x));
            chk("pix_y",   32'(pix_y),   32'(e1.y));
            chk("pix_rgb", 32'(pix_rgb), 32'(e1.rgb));
        end
        if (frame_done) begin
            done_cnt++;
            last_sum = frame_sum;
        end
        if (err_geom) err_cnt++;
        e1 = e0;
        e0.v = ev;
        e0.x = 11'(ex);
        e0.y = 11'(ey);
        e0.rgb = rgb;
        e0.sof = esof;
        vif.hs = hs;
        vif.vs = vs;
        vif.blank = blank;
        vif.rgb = rgb;
    endtask

    task automatic idle(input logic vs);
        cyc(1'b1, vs, 1'b0, 24'd0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic blank_line(input logic vs);
        for (int i = 0; i < 2; i++) cyc(1'b0, vs, 1'b0, 24'd0, 1'b0, 0, 0, 1'b0);
        for (int i = 0; i < 10; i++) idle(vs);
    endtask

    task automatic do_reset();
        #2 sys_rst = 1'b1;
        #1 chk_zero("midrst");
        e0 = '{default: '0};
        e1 = '{default: '0};
        search = 1'b1;
        @(negedge pixel_clk);
        sys_rst = 1'b0;
    endtask

    // VS and HS fall together at the start of every frame.
    task automatic send_frame(input int nlines, input int bad_line, input int bad_len,
                              input int mode, input int rst_line);
        int n;
        blank_line(1'b0);
        search = 1'b0;
        blank_line(1'b1);
        for (int l = 0; l < nlines; l++) begin
            n = (l == bad_line) ? bad_len : HD;
            for (int i = 0; i < 2; i++) cyc(1'b0, 1'b1, 1'b0, 24'd0, 1'b0, 0, 0, 1'b0);
            for (int i = 0; i < 2; i++) idle(1'b1);
            for (int p = 0; p < n; p++) begin
                cyc(1'b1, 1'b1, 1'b1, rgb_of(mode, p, l), !search, p, l, !search && l == 0 && p == 0);
                if (l == rst_line && p == 3) do_reset();
            end
            for (int i = 0; i < 2; i++) idle(1'b1);
        end
        blank_line(1'b1);
    endtask

    task automatic chk_frame(input string tag, input int exp_locked, input int exp_cnt,
                             input int exp_done, input logic [23:0] exp_sum, input int exp_err);
        chk({tag, " locked"},    32'(locked),    32'(exp_locked));
        chk({tag, " frame_cnt"}, 32'(frame_cnt), 32'(exp_cnt));
        chk({tag, " done_cnt"},  32'(done_cnt),  32'(exp_done));
        chk({tag, " err_cnt"},   32'(err_cnt),   32'(exp_err));
        if (exp_done != 0) chk({tag, " frame_sum"}, 32'(last_sum), 32'(exp_sum));
    endtask

    initial begin
        #400000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        //           lines bad len mode | lock cnt done sum          err
        rows[0] = '{4, -1, 0, 0, 0, 0, 0, 24'h000000, 0};  // first VS fall leaves SEARCH
        rows[1] = '{4, -1, 0, 0, 1, 1, 1, 24'h000370, 0};  // lock on 2nd VS fall
        rows[2] = '{4, -1, 0, 0, 1, 2, 1, 24'h000370, 0};
        rows[3] = '{4,  2, 7, 0, 1, 3, 1, 24'h000370, 1};  // short line 2
        rows[4] = '{4, -1, 0, 0, 0, 3, 1, 24'h000349, 0};  // lock lost, count holds
        rows[5] = '{4, -1, 0, 0, 1, 1, 1, 24'h000370, 0};  // relock from CHECK
        rows[6] = '{5, -1, 0, 0, 1, 2, 1, 24'h000370, 0};  // extra line, y reaches 4
        rows[7] = '{4, -1, 0, 1, 0, 2, 1, 24'h00058C, 1};  // height error at VS fall
        rows[8] = '{4, -1, 0, 2, 1, 1, 1, 24'h000020, 0};  // 32 x 0x000001
        rows[9] = '{4, -1, 0, 0, 1, 2, 1, 24'hFFFFFE, 0};  // 2 x 0xFFFFFF

        e0 = '{default: '0};
        e1 = '{default: '0};
        vif.hs = 1'b1;
        vif.vs = 1'b1;
        vif.blank = 1'b0;
        vif.rgb = 24'd0;
        repeat (3) @(negedge pixel_clk);
        chk_zero("reset");
        sys_rst = 1'b0;
        repeat (4) idle(1'b1);

        for (int r = 0; r < 10; r++) begin
            err_cnt = 0;
            done_cnt = 0;
            send_frame(rows[r].nlines, rows[r].bad_line, rows[r].bad_len, rows[r].mode, -1);
            chk_frame($sformatf("row%0d", r), rows[r].exp_locked, rows[r].exp_cnt,
                      rows[r].exp_done, rows[r].exp_sum, rows[r].exp_err);
        end

        // reset during row 2: partial frame is ignored, lock returns a frame later
        send_frame(4, -1, 0, 0, 2);
        chk("postrst locked", 32'(locked), 32'd0);
        chk("postrst frame_cnt", 32'(frame_cnt), 32'd0);
        err_cnt = 0;
        done_cnt = 0;
        send_frame(4, -1, 0, 0, -1);
        chk_frame("rst_search", 0, 0, 0, 24'h0, 0);
        err_cnt = 0;
        done_cnt = 0;
        send_frame(4, -1, 0, 0, -1);
        chk_frame("rst_relock", 1, 1, 1, 24'h000370, 0);

        repeat (4) idle(1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
